// File: rtl/cpu_pkg.sv
// Shared constants for the 16-instruction, 4-bit-opcode CPU.
// Holds the opcode map, the ALU operation encodings and the control-unit
// state type used by control and control_decode.
package cpu_pkg;

    // Opcode map
    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_XOR  = 4'h2;
    localparam logic [3:0] OP_NOT  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_CMP  = 4'h6;
    localparam logic [3:0] OP_J    = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_BNE  = 4'h9;
    localparam logic [3:0] OP_SL   = 4'hA;
    localparam logic [3:0] OP_SR   = 4'hB;
    localparam logic [3:0] OP_ADDI = 4'hC;
    localparam logic [3:0] OP_LUI  = 4'hD;
    localparam logic [3:0] OP_LW   = 4'hE;
    localparam logic [3:0] OP_SW   = 4'hF;

    // ALU operations; register-register ops reuse their opcode value
    localparam logic [3:0] ALU_AND = 4'h0;
    localparam logic [3:0] ALU_OR  = 4'h1;
    localparam logic [3:0] ALU_XOR = 4'h2;
    localparam logic [3:0] ALU_NOT = 4'h3;
    localparam logic [3:0] ALU_ADD = 4'h4;
    localparam logic [3:0] ALU_SUB = 4'h5;
    localparam logic [3:0] ALU_CMP = 4'h6;
    localparam logic [3:0] ALU_SL  = 4'hA;
    localparam logic [3:0] ALU_SR  = 4'hB;
    localparam logic [3:0] ALU_LUI = 4'hD;

    // Control-unit states
    typedef enum logic {
        S_FETCH = 1'b0,
        S_EXEC  = 1'b1
    } state_e;

endpackage

// File: rtl/control_decode.sv
// Purely combinational EXECUTE-phase decoder.
// Inputs : opcode (4) instruction opcode, Eq comparator equality flag.
// Outputs: datapath selects (M13, M2, M457, M6), memory address select,
//          register-file / memory write enables and the 4-bit ALU op.
// pc_flag and instruction_flag are constant in EXECUTE and live in control.
module control_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       Eq,
    output logic       M13,
    output logic       M2,
    output logic       M457,
    output logic       M6,
    output logic       change_address_flag,
    output logic       Wr_en_rf,
    output logic       Wr_en,
    output logic [3:0] ALU
);

    always_comb begin
        M13                 = 1'b0;
        M2                  = 1'b0;
        M457                = 1'b0;
        M6                  = 1'b0;
        change_address_flag = 1'b0;
        Wr_en_rf            = 1'b0;
        Wr_en               = 1'b0;
        ALU                 = ALU_AND;

        case (opcode)
            OP_AND: begin Wr_en_rf = 1'b1; ALU = ALU_AND; end
            OP_OR:  begin Wr_en_rf = 1'b1; ALU = ALU_OR;  end
            OP_XOR: begin Wr_en_rf = 1'b1; ALU = ALU_XOR; end
            OP_NOT: begin Wr_en_rf = 1'b1; ALU = ALU_NOT; end
            OP_ADD: begin Wr_en_rf = 1'b1; ALU = ALU_ADD; end
            OP_SUB: begin Wr_en_rf = 1'b1; ALU = ALU_SUB; end
            OP_CMP: begin Wr_en_rf = 1'b1; ALU = ALU_CMP; end
            OP_SL:  begin Wr_en_rf = 1'b1; ALU = ALU_SL;  end
            OP_SR:  begin Wr_en_rf = 1'b1; ALU = ALU_SR;  end
            OP_J: begin
                M6 = 1'b1;
            end
            // Branches compare rd against rs, so read port B takes the rd field
            OP_BEQ: begin
                M457 = 1'b1;
                M6   = Eq;
                ALU  = ALU_SUB;
            end
            OP_BNE: begin
                M457 = 1'b1;
                M6   = ~Eq;
                ALU  = ALU_SUB;
            end
            OP_ADDI: begin
                M13      = 1'b1;
                Wr_en_rf = 1'b1;
                ALU      = ALU_ADD;
            end
            OP_LUI: begin
                M13      = 1'b1;
                Wr_en_rf = 1'b1;
                ALU      = ALU_LUI;
            end
            // Loads/stores form base + immediate in the ALU and address memory with it
            OP_LW: begin
                M13                 = 1'b1;
                M2                  = 1'b1;
                change_address_flag = 1'b1;
                Wr_en_rf            = 1'b1;
                ALU                 = ALU_ADD;
            end
            OP_SW: begin
                M13                 = 1'b1;
                M457                = 1'b1;
                change_address_flag = 1'b1;
                Wr_en               = 1'b1;
                ALU                 = ALU_ADD;
            end
            default: begin
                M6 = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/control.sv
// Two-state FETCH/EXECUTE multi-cycle control unit.
// Inputs : clk, reset (async, active-low), opcode (4), Eq.
// Outputs: M13, M2, M457, M6 datapath selects; pc_flag, instruction_flag
//          load enables; change_address_flag memory address select;
//          Wr_en_rf, Wr_en write enables; state (0 FETCH, 1 EXECUTE); ALU (4).
// Every instruction takes one FETCH and one EXECUTE cycle. All outputs are
// forced to 0 while reset is low, including the FETCH-only instruction_flag.
module control
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       Eq,
    output logic       M13,
    output logic       M2,
    output logic       M457,
    output logic       M6,
    output logic       pc_flag,
    output logic       instruction_flag,
    output logic       change_address_flag,
    output logic       Wr_en_rf,
    output logic       state,
    output logic [3:0] ALU,
    output logic       Wr_en
);

    state_e state_q, state_d;

    logic       dec_m13;
    logic       dec_m2;
    logic       dec_m457;
    logic       dec_m6;
    logic       dec_change_address_flag;
    logic       dec_wr_en_rf;
    logic       dec_wr_en;
    logic [3:0] dec_alu;

    control_decode u_decode (
        .opcode              (opcode),
        .Eq                  (Eq),
        .M13                 (dec_m13),
        .M2                  (dec_m2),
        .M457                (dec_m457),
        .M6                  (dec_m6),
        .change_address_flag (dec_change_address_flag),
        .Wr_en_rf            (dec_wr_en_rf),
        .Wr_en               (dec_wr_en),
        .ALU                 (dec_alu)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = (state_q == S_FETCH) ? S_EXEC : S_FETCH;

        M13                 = 1'b0;
        M2                  = 1'b0;
        M457                = 1'b0;
        M6                  = 1'b0;
        pc_flag             = 1'b0;
        instruction_flag    = 1'b0;
        change_address_flag = 1'b0;
        Wr_en_rf            = 1'b0;
        Wr_en               = 1'b0;
        ALU                 = 4'h0;

        // The state register clears asynchronously, but instruction_flag would
        // still read 1 in FETCH, so gate the outputs on reset directly.
        if (reset) begin
            if (state_q == S_FETCH) begin
                instruction_flag = 1'b1;
            end else begin
                pc_flag             = 1'b1;
                M13                 = dec_m13;
                M2                  = dec_m2;
                M457                = dec_m457;
                M6                  = dec_m6;
                change_address_flag = dec_change_address_flag;
                Wr_en_rf            = dec_wr_en_rf;
                Wr_en               = dec_wr_en;
                ALU                 = dec_alu;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_control.sv
// Self-checking bench for control: randomized opcode/Eq/reset stimulus checked
// every cycle against a table-driven behavioural model, plus directed checks
// with hand-computed literal expectations.
module tb_control;

    logic       clk;
    logic       reset;
    logic [3:0] opcode;
    logic       Eq;
    logic       M13, M2, M457, M6, pc_flag, instruction_flag, change_address_flag;
    logic       Wr_en_rf, state, Wr_en;
    logic [3:0] ALU;

    int n_cmp  = 0;
    int n_fail = 0;

    control dut (
        .clk                 (clk),
        .reset               (reset),
        .opcode              (opcode),
        .Eq                  (Eq),
        .M13                 (M13),
        .M2                  (M2),
        .M457                (M457),
        .M6                  (M6),
        .pc_flag             (pc_flag),
        .instruction_flag    (instruction_flag),
        .change_address_flag (change_address_flag),
        .Wr_en_rf            (Wr_en_rf),
        .state               (state),
        .ALU                 (ALU),
        .Wr_en               (Wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit i of each mask set means opcode i asserts that output in EXECUTE
    localparam logic [15:0] WR_RF_MASK = 16'b0111_1100_0111_1111;
    localparam logic [15:0] M13_MASK   = 16'b1111_0000_0000_0000;
    localparam logic [15:0] M457_MASK  = 16'b1000_0011_0000_0000;
    localparam logic [15:0] CAF_MASK   = 16'b1100_0000_0000_0000;
    // ALU op per opcode, opcode F in the top nibble
    localparam logic [63:0] ALU_TAB = {4'h4, 4'h4, 4'hD, 4'h4, 4'hB, 4'hA, 4'h5, 4'h5,
                                       4'h0, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0};

    logic [13:0] dut_vec;
    assign dut_vec = {M13, M2, M457, M6, pc_flag, instruction_flag, change_address_flag,
                      Wr_en_rf, state, ALU, Wr_en};

    // Edges since reset release: odd count means the instruction is executing
    int unsigned edges;
    always @(posedge clk or negedge reset) begin
        if (!reset) edges <= 0;
        else        edges <= edges + 1;
    end

    function automatic logic [13:0] model(logic rst_n, int unsigned n_edges,
                                          logic [3:0] op, logic eq);
        logic ex;
        logic jump;
        int   i;
        i  = int'(op);
        ex = (n_edges % 2) == 1;
        if (!rst_n) return 14'h0;
        if (!ex) return {5'b0, 1'b1, 8'b0};
        jump = (op == 4'h7) || (op == 4'h8 && eq) || (op == 4'h9 && !eq);
        return {M13_MASK[i], op == 4'hE, M457_MASK[i], jump, 1'b1, 1'b0, CAF_MASK[i],
                WR_RF_MASK[i], 1'b1, ALU_TAB[i*4 +: 4], op == 4'hF};
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (op=%h Eq=%b reset=%b t=%0t)",
                     name, act, exp, opcode, Eq, reset, $time);
        end
    endtask

    task automatic check_now(string name);
        check(name, {2'b0, dut_vec}, {2'b0, model(reset, edges, opcode, Eq)});
    endtask

    always @(negedge clk) check_now("cycle_model");

    task automatic in_exec();
        @(negedge clk);
        if (edges % 2 == 0) @(negedge clk);
        #1;
    endtask

    task automatic in_fetch();
        @(negedge clk);
        if (edges % 2 == 1) @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset  = 1'b0;
        opcode = 4'h0;
        Eq     = 1'b0;

        // Reset held across two edges
        repeat (2) @(posedge clk);
        #1;
        check("reset.all_zero", {2'b0, dut_vec}, 16'h0);
        check("reset.instr_flag", {15'b0, instruction_flag}, 16'h0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("release.state", {15'b0, state}, 16'h0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 check($sformatf("seq.state%0d", i), {15'b0, state}, (i % 2 == 0) ? 16'h1 : 16'h0);
        end

        // FETCH ignores opcode and Eq
        in_fetch();
        opcode = 4'($urandom);
        Eq     = 1'($urandom);
        #1;
        check("fetch.instr_flag", {15'b0, instruction_flag}, 16'h1);
        check("fetch.pc_flag", {15'b0, pc_flag}, 16'h0);
        check("fetch.wr_en", {14'b0, Wr_en, Wr_en_rf}, 16'h0);
        check("fetch.caf", {15'b0, change_address_flag}, 16'h0);
        check("fetch.alu", {12'b0, ALU}, 16'h0);

        // ADD, then ADDI within the same EXECUTE cycle
        in_exec();
        opcode = 4'h4;
        Eq     = 1'($urandom);
        #1;
        check("add.wr_en_rf", {15'b0, Wr_en_rf}, 16'h1);
        check("add.alu", {12'b0, ALU}, 16'h4);
        check("add.m13_m2_m6", {13'b0, M13, M2, M6}, 16'h0);
        check("add.pc_instr", {14'b0, pc_flag, instruction_flag}, 16'h2);
        opcode = 4'hC;
        #1;
        check("addi.m13", {15'b0, M13}, 16'h1);
        check("addi.alu", {12'b0, ALU}, 16'h4);

        // Branches and jump
        in_exec();
        opcode = 4'h8;
        Eq     = 1'b1;
        #1;
        check("beq.taken.m6", {15'b0, M6}, 16'h1);
        check("beq.alu", {12'b0, ALU}, 16'h5);
        check("beq.wr_en_rf", {15'b0, Wr_en_rf}, 16'h0);
        Eq = 1'b0;
        #1 check("beq.not_taken.m6", {15'b0, M6}, 16'h0);
        in_exec();
        opcode = 4'h9;
        Eq     = 1'b0;
        #1 check("bne.taken.m6", {15'b0, M6}, 16'h1);
        Eq = 1'b1;
        #1 check("bne.not_taken.m6", {15'b0, M6}, 16'h0);
        in_exec();
        opcode = 4'h7;
        Eq     = 1'($urandom);
        #1;
        check("j.m6", {15'b0, M6}, 16'h1);
        check("j.alu", {12'b0, ALU}, 16'h0);

        // Memory ops and LUI
        in_exec();
        opcode = 4'hE;
        #1;
        check("lw.m2_m13", {14'b0, M2, M13}, 16'h3);
        check("lw.caf", {15'b0, change_address_flag}, 16'h1);
        check("lw.wr", {14'b0, Wr_en_rf, Wr_en}, 16'h2);
        opcode = 4'hF;
        #1;
        check("sw.wr", {14'b0, Wr_en_rf, Wr_en}, 16'h1);
        check("sw.m457_caf", {14'b0, M457, change_address_flag}, 16'h3);
        in_exec();
        opcode = 4'hD;
        #1 check("lui.alu", {12'b0, ALU}, 16'hD);

        // Full opcode/Eq sweep in EXECUTE against the model
        for (int op = 0; op < 16; op++) begin
            for (int e = 0; e < 2; e++) begin
                in_exec();
                opcode = 4'(op);
                Eq     = 1'(e);
                #1 check_now($sformatf("sweep.op%0h.eq%0d", op, e));
            end
        end

        // Reset pulled low mid-EXECUTE clears outputs without a clock
        in_exec();
        opcode = 4'hF;
        #1 check("midrst.pre.wr_en", {15'b0, Wr_en}, 16'h1);
        reset = 1'b0;
        #1;
        check("midrst.all_zero", {2'b0, dut_vec}, 16'h0);
        check("midrst.state", {15'b0, state}, 16'h0);
        @(negedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1 check("midrst.release.state", {15'b0, state}, 16'h1);

        // Randomized traffic with mid-cycle opcode changes and reset pulses
        repeat (400) begin
            @(posedge clk);
            #1;
            opcode = 4'($urandom);
            Eq     = 1'($urandom);
            if ($urandom_range(0, 29) == 0) begin
                reset = 1'b0;
                #6 reset = 1'b1;
            end else begin
                #6;
                opcode = 4'($urandom);
                Eq     = 1'($urandom);
                #1 check_now("rand.mid_cycle");
            end
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/control.md
Name: control

Overview:
- Two-state (FETCH/EXECUTE) multi-cycle control unit for the 16-instruction, 4-bit-opcode CPU.
- Decodes `opcode` and the comparator flag `Eq` into datapath mux selects, register/memory enables and a 4-bit ALU operation.
- Sits between the instruction register and the datapath: PC, instruction register, register file, ALU and a unified memory.

Parameters:
- none (opcode and ALU encodings are fixed constants in the shared package)

Ports:
- `clk`  in  1  system clock, rising-edge active
- `reset`  in  1  asynchronous, active-low reset
- `opcode`  in  4  instruction opcode field from the instruction register
- `Eq`  in  1  register-equality flag from the datapath comparator
- `M13`  out  1  ALU operand-B select: 1 = immediate, 0 = register read B
- `M2`  out  1  register-file write-data select: 1 = memory read data, 0 = ALU result
- `M457`  out  1  register-file read-address-B select: 1 = destination field (SW/BEQ/BNE), 0 = source-2 field
- `M6`  out  1  next-PC select: 1 = jump/branch target, 0 = PC+1
- `pc_flag`  out  1  PC load enable
- `instruction_flag`  out  1  instruction register load enable
- `change_address_flag`  out  1  memory address select: 1 = ALU result, 0 = PC
- `Wr_en_rf`  out  1  register-file write enable
- `state`  out  1  current state: 0 = FETCH, 1 = EXECUTE
- `ALU`  out  4  ALU operation code
- `Wr_en`  out  1  data-memory write enable

Behaviour:
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 NOT, 4 ADD, 5 SUB, 6 CMP, 7 J, 8 BEQ, 9 BNE, A SL, B SR, C ADDI, D LUI, E LW, F SW.
- State register: async clear to FETCH when `reset` = 0.
- Transitions: FETCH -> EXECUTE -> FETCH on every rising edge; no stalls, no other states. Each instruction takes exactly 2 cycles.
- While `reset` = 0, every output is 0, including `instruction_flag` and `state`.
- FETCH outputs (opcode and `Eq` ignored):
  - `instruction_flag` = 1, `change_address_flag` = 0.
  - All other outputs 0; `ALU` = 0.
- EXECUTE outputs are combinational from `opcode` and `Eq`:
  - `pc_flag` = 1 for all opcodes; `instruction_flag` = 0.
  - `M6` = 1 for J; for BEQ when `Eq` = 1; for BNE when `Eq` = 0; else 0.
  - `Wr_en_rf` = 1 for opcodes 0-6, A, B, C, D, E; 0 for 7, 8, 9, F.
  - `Wr_en` = 1 only for F (SW).
  - `M13` = 1 for C, D, E, F.
  - `M2` = 1 only for E (LW).
  - `M457` = 1 for 8, 9, F.
  - `change_address_flag` = 1 for E and F.
- `ALU` encoding, EXECUTE only:
  - Equals `opcode` for 0-6, A, B.
  - 4 (ADD) for C, E, F.
  - 5 (SUB) for 8, 9.
  - D (pass immediate shifted to upper half) for D.
  - 0 for 7.
- `Eq` affects only `M6` in EXECUTE.
- An opcode change during a state takes effect combinationally; the state sequence is unaffected.
- Reset asserted mid-EXECUTE: the state clears immediately and outputs go to 0 in the same cycle. On release, the first rising edge goes FETCH -> EXECUTE.
- No X outputs for any opcode/`Eq` combination; use full `case` with defaults.

Decomposition:
- Shared package `cpu_pkg`:
  - Opcode localparams (OP_AND..OP_SW).
  - ALU op localparams.
  - State constants S_FETCH = 0, S_EXEC = 1.
- Optional sub-module `control_decode`: purely combinational opcode/`Eq` -> EXECUTE-output decoder. `control` keeps the state register and the FETCH/reset gating.

Test Plan:
- Hold `reset` = 0 for 2 edges -> all outputs 0, `state` = 0. Release -> `state` toggles 0,1,0,1 on successive edges.
- FETCH with any opcode -> `instruction_flag` = 1, `pc_flag` = `Wr_en` = `Wr_en_rf` = 0, `change_address_flag` = 0.
- EXECUTE `opcode` = 4 (ADD) -> `Wr_en_rf` = 1, `ALU` = 4, `M13` = 0, `M2` = 0, `M6` = 0, `pc_flag` = 1. Same with `opcode` = C -> `M13` = 1, `ALU` = 4.
- EXECUTE BEQ(8): `Eq` = 1 -> `M6` = 1; `Eq` = 0 -> `M6` = 0; `ALU` = 5, `Wr_en_rf` = 0. BNE(9): `Eq` = 0 -> `M6` = 1; `Eq` = 1 -> `M6` = 0. J(7) -> `M6` = 1.
- EXECUTE LW(E) -> `M2` = 1, `M13` = 1, `change_address_flag` = 1, `Wr_en_rf` = 1, `Wr_en` = 0. SW(F) -> `Wr_en` = 1, `Wr_en_rf` = 0, `M457` = 1, `change_address_flag` = 1.
- Sweep opcodes 0-F in EXECUTE and compare every output against the decode rules. Then pull `reset` low mid-EXECUTE -> outputs 0 immediately, no clock needed.
